// File: rtl/fpaddsub_prealign_pipe_if.sv
// Operand/result handshake bundle for the FP add/sub pre-alignment pipeline.
// The DUT side uses the slave modport; the producer/consumer side uses master.
interface fpaddsub_prealign_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int GRD_W = 1
);
    logic                   in_valid;
    logic                   in_ready;
    logic [EXP_W+MAN_W:0]   in_a;
    logic [EXP_W+MAN_W:0]   in_b;
    logic                   in_op;
    logic                   out_valid;
    logic                   out_ready;
    logic                   out_sx;
    logic                   out_sy;
    logic [EXP_W-1:0]       out_ex;
    logic [MAN_W+GRD_W:0]   out_mx;
    logic [MAN_W+GRD_W:0]   out_my;
    logic [EXP_W-1:0]       out_shift;
    logic                   out_swap;
    logic                   out_nan;
    logic                   out_inf;

    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_sx, out_sy, out_ex, out_mx, out_my,
               out_shift, out_swap, out_nan, out_inf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_sx, out_sy, out_ex, out_mx, out_my,
               out_shift, out_swap, out_nan, out_inf
    );
endinterface

// File: rtl/fpaddsub_prealign_pipe.sv
// Two-stage FP add/sub pre-alignment: unpack/classify (S1), then magnitude order and shift (S2).
// Define FPADDSUB_DENORM_EN to keep denormal fractions; otherwise denormal inputs flush to zero.
module fpaddsub_prealign_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int GRD_W = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    fpaddsub_prealign_pipe_if.slave bus
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int MW = MAN_W + 1 + GRD_W;
    localparam logic [EXP_W:0] SAT_SHIFT = (EXP_W+1)'(MAN_W + GRD_W + 2);

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MW-1:0]    mant;
        logic             inf;
        logic             nan;
    } opnd_t;

    function automatic opnd_t unpack_opnd(input logic sign, input logic [EXP_W-1:0] exp,
                                          input logic [MAN_W-1:0] frac);
        opnd_t o;
        logic  exp_zero;
        logic  exp_ones;
        exp_zero = ~|exp;
        exp_ones = &exp;
        o.sign   = sign;
        o.exp    = exp_zero ? EXP_W'(1) : exp;
`ifdef FPADDSUB_DENORM_EN
        o.mant   = {~exp_zero, frac, {GRD_W{1'b0}}};
`else
        o.mant   = exp_zero ? '0 : {1'b1, frac, {GRD_W{1'b0}}};
`endif
        o.inf    = exp_ones & ~|frac;
        o.nan    = exp_ones & |frac;
        return o;
    endfunction

    logic             s1_adv, s2_adv;
    logic             s1_valid_q, s1_valid_d;
    opnd_t            s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic             s2_valid_q, s2_valid_d;
    logic             sx_q, sx_d, sy_q, sy_d;
    logic [EXP_W-1:0] ex_q, ex_d, shift_q, shift_d;
    logic [MW-1:0]    mx_q, mx_d, my_q, my_d;
    logic             swap_q, swap_d, nan_q, nan_d, inf_q, inf_d;
    logic             swap_c;
    logic [EXP_W:0]   diff_c;

    always_comb begin
        s2_adv     = ~s2_valid_q | bus.out_ready;
        s1_adv     = ~s1_valid_q | s2_adv;
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s2_valid_d = s2_valid_q;
        sx_d       = sx_q;
        sy_d       = sy_q;
        ex_d       = ex_q;
        mx_d       = mx_q;
        my_d       = my_q;
        shift_d    = shift_q;
        swap_d     = swap_q;
        nan_d      = nan_q;
        inf_d      = inf_q;

        // Ties keep A as X, so only a strictly larger B swaps.
        swap_c = {s1_b_q.exp, s1_b_q.mant} > {s1_a_q.exp, s1_a_q.mant};
        diff_c = swap_c ? ({1'b0, s1_b_q.exp} - {1'b0, s1_a_q.exp})
                        : ({1'b0, s1_a_q.exp} - {1'b0, s1_b_q.exp});

        if (s1_adv) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_a_d = unpack_opnd(bus.in_a[W-1], bus.in_a[W-2 -: EXP_W], bus.in_a[MAN_W-1:0]);
                s1_b_d = unpack_opnd(bus.in_b[W-1] ^ bus.in_op, bus.in_b[W-2 -: EXP_W],
                                     bus.in_b[MAN_W-1:0]);
            end
        end

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                swap_d  = swap_c;
                sx_d    = swap_c ? s1_b_q.sign : s1_a_q.sign;
                sy_d    = swap_c ? s1_a_q.sign : s1_b_q.sign;
                ex_d    = swap_c ? s1_b_q.exp  : s1_a_q.exp;
                mx_d    = swap_c ? s1_b_q.mant : s1_a_q.mant;
                my_d    = swap_c ? s1_a_q.mant : s1_b_q.mant;
                shift_d = (diff_c > SAT_SHIFT) ? SAT_SHIFT[EXP_W-1:0] : diff_c[EXP_W-1:0];
                nan_d   = s1_a_q.nan | s1_b_q.nan
                        | (s1_a_q.inf & s1_b_q.inf & (s1_a_q.sign ^ s1_b_q.sign));
                inf_d   = (s1_a_q.inf | s1_b_q.inf)
                        & ~(s1_a_q.nan | s1_b_q.nan
                            | (s1_a_q.inf & s1_b_q.inf & (s1_a_q.sign ^ s1_b_q.sign)));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s2_valid_q <= 1'b0;
            sx_q       <= 1'b0;
            sy_q       <= 1'b0;
            ex_q       <= '0;
            mx_q       <= '0;
            my_q       <= '0;
            shift_q    <= '0;
            swap_q     <= 1'b0;
            nan_q      <= 1'b0;
            inf_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s2_valid_q <= s2_valid_d;
            sx_q       <= sx_d;
            sy_q       <= sy_d;
            ex_q       <= ex_d;
            mx_q       <= mx_d;
            my_q       <= my_d;
            shift_q    <= shift_d;
            swap_q     <= swap_d;
            nan_q      <= nan_d;
            inf_q      <= inf_d;
        end
    end

    assign bus.in_ready  = s1_adv;
    assign bus.out_valid = s2_valid_q;
    assign bus.out_sx    = sx_q;
    assign bus.out_sy    = sy_q;
    assign bus.out_ex    = ex_q;
    assign bus.out_mx    = mx_q;
    assign bus.out_my    = my_q;
    assign bus.out_shift = shift_q;
    assign bus.out_swap  = swap_q;
    assign bus.out_nan   = nan_q;
    assign bus.out_inf   = inf_q;
endmodule

// File: tb/tb_fpaddsub_prealign_pipe.sv
// Self-checking bench for fpaddsub_prealign_pipe: directed vectors, backpressure, reset, random traffic.
module tb_fpaddsub_prealign_pipe;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int GRD_W = 1;
`ifdef FPADDSUB_DENORM_EN
    localparam bit DENORM = 1'b1;
`else
    localparam bit DENORM = 1'b0;
`endif

    typedef struct packed {
        logic        sx;
        logic        sy;
        logic [7:0]  ex;
        logic [24:0] mx;
        logic [24:0] my;
        logic [7:0]  shift;
        logic        swap;
        logic        nan;
        logic        inf;
    } res_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    res_t exp_q[$];

    fpaddsub_prealign_pipe_if #(.EXP_W(EXP_W), .MAN_W(MAN_W), .GRD_W(GRD_W)) bus ();

    fpaddsub_prealign_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .GRD_W(GRD_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic res_t mk(input logic sx, input logic sy, input logic [7:0] ex,
                                input logic [24:0] mx, input logic [24:0] my,
                                input logic [7:0] shift, input logic swap,
                                input logic nan, input logic inf);
        res_t r;
        r.sx = sx; r.sy = sy; r.ex = ex; r.mx = mx; r.my = my;
        r.shift = shift; r.swap = swap; r.nan = nan; r.inf = inf;
        return r;
    endfunction

    function automatic res_t observe();
        return mk(bus.out_sx, bus.out_sy, bus.out_ex, bus.out_mx, bus.out_my,
                  bus.out_shift, bus.out_swap, bus.out_nan, bus.out_inf);
    endfunction

    // Reference: magnitudes as plain integers, ordering by numeric compare.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic op);
        res_t r;
        longint unsigned ea, eb, fa, fb, ma, mb, ka, kb, d;
        bit sa, sb, infa, infb, nana, nanb, swp;
        sa = a[31];
        sb = b[31] ^ op;
        ea = longint'(a[30:23]); eb = longint'(b[30:23]);
        fa = longint'(a[22:0]);  fb = longint'(b[22:0]);
        infa = (ea == 255) && (fa == 0);
        nana = (ea == 255) && (fa != 0);
        infb = (eb == 255) && (fb == 0);
        nanb = (eb == 255) && (fb != 0);
        if (ea == 0) ma = DENORM ? fa : 0; else ma = fa + (64'd1 << 23);
        if (eb == 0) mb = DENORM ? fb : 0; else mb = fb + (64'd1 << 23);
        ma = ma * 2;
        mb = mb * 2;
        if (ea == 0) ea = 1;
        if (eb == 0) eb = 1;
        ka = ea * (64'd1 << 25) + ma;
        kb = eb * (64'd1 << 25) + mb;
        swp = kb > ka;
        r.swap = swp;
        if (swp) begin
            r.sx = sb; r.sy = sa; r.ex = 8'(eb); r.mx = 25'(mb); r.my = 25'(ma); d = eb - ea;
        end else begin
            r.sx = sa; r.sy = sb; r.ex = 8'(ea); r.mx = 25'(ma); r.my = 25'(mb); d = ea - eb;
        end
        r.shift = (d > 26) ? 8'd26 : 8'(d);
        r.nan = nana || nanb || (infa && infb && (sa != sb));
        r.inf = (infa || infb) && !r.nan;
        return r;
    endfunction

    function automatic logic [31:0] randOperand();
        logic [7:0]  e;
        logic [22:0] f;
        case ($urandom_range(0, 5))
            0:       e = 8'h00;
            1:       e = 8'hFF;
            2:       e = 8'h7F;
            default: e = 8'($urandom);
        endcase
        f = ($urandom_range(0, 3) == 0) ? 23'd0 : 23'($urandom);
        return {1'($urandom), e, f};
    endfunction

    task automatic checkRes(input string tag, input res_t obs, input res_t expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic checkInt(input string tag, input int obs, input int expv);
        n_tests++;
        assert (obs == expv) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b, input logic op);
        bus.in_valid = v;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_op    = op;
    endtask

    // Present one pair for a single cycle into an empty pipe and confirm it is taken.
    task automatic applyStimulus(input string tag, input logic [31:0] a, input logic [31:0] b,
                                 input logic op);
        drive(1'b1, a, b, op);
        @(negedge clk);
        checkBit({tag, "_accept"}, bus.in_ready, 1'b1);
        @(posedge clk); #1;
        drive(1'b0, $urandom, $urandom, 1'($urandom));
    endtask

    task automatic checkOutput(input string tag, input res_t expv);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        checkBit({tag, "_valid"}, bus.out_valid, 1'b1);
        checkInt({tag, "_latency"}, n, 1);
        checkRes(tag, observe(), expv);
        @(posedge clk); #1;
    endtask

    // One random-traffic cycle with scoreboard bookkeeping at the negedge.
    task automatic tick();
        res_t e;
        @(negedge clk);
        if (bus.in_valid && bus.in_ready)
            exp_q.push_back(model(bus.in_a, bus.in_b, bus.in_op));
        if (bus.out_valid && bus.out_ready) begin
            checkBit("rand_pop_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checkRes("rand_result", observe(), e);
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] p1a, p1b, p2a, p2b, p3a, p3b;
        res_t        e1, e2, e3;
        int          seen;

        rst_n = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkBit("reset_out_valid", bus.out_valid, 1'b0);
        checkBit("reset_in_ready", bus.in_ready, 1'b1);
        checkRes("reset_data", observe(), '0);
        @(posedge clk); #1;

        applyStimulus("one_plus_two", 32'h3F800000, 32'h40000000, 1'b0);
        checkOutput("one_plus_two", mk(0, 0, 8'h80, 25'h1000000, 25'h1000000, 8'd1, 1, 0, 0));

        applyStimulus("denorm", 32'h00000001, 32'h00000000, 1'b0);
        checkOutput("denorm", mk(0, 0, 8'h01, DENORM ? 25'h2 : 25'h0, 25'h0, 8'd0, 0, 0, 0));

        applyStimulus("inf_minus_inf", 32'h7F800000, 32'h7F800000, 1'b1);
        checkOutput("inf_minus_inf", mk(0, 1, 8'hFF, 25'h1000000, 25'h1000000, 8'd0, 0, 1, 0));

        applyStimulus("inf_plus_inf", 32'h7F800000, 32'h7F800000, 1'b0);
        checkOutput("inf_plus_inf", mk(0, 0, 8'hFF, 25'h1000000, 25'h1000000, 8'd0, 0, 0, 1));

        applyStimulus("shift_sat", 32'h7F000000, 32'h3F800000, 1'b0);
        checkOutput("shift_sat", mk(0, 0, 8'hFE, 25'h1000000, 25'h1000000, 8'd26, 0, 0, 0));

        applyStimulus("neg_sub", 32'hC0400000, 32'h3F800000, 1'b1);
        checkOutput("neg_sub", mk(1, 1, 8'h80, 25'h1800000, 25'h1000000, 8'd1, 0, 0, 0));

        // Backpressure: fill both stages, stall, then drain with a concurrent push.
        p1a = randOperand(); p1b = randOperand();
        p2a = randOperand(); p2b = randOperand();
        p3a = randOperand(); p3b = randOperand();
        e1 = model(p1a, p1b, 1'b0);
        e2 = model(p2a, p2b, 1'b1);
        e3 = model(p3a, p3b, 1'b0);
        bus.out_ready = 1'b0;
        drive(1'b1, p1a, p1b, 1'b0);
        @(negedge clk); checkBit("bp_accept1", bus.in_ready, 1'b1);
        @(posedge clk); #1;
        drive(1'b1, p2a, p2b, 1'b1);
        @(negedge clk); checkBit("bp_accept2", bus.in_ready, 1'b1);
        @(posedge clk); #1;
        drive(1'b1, p3a, p3b, 1'b0);
        @(negedge clk);
        checkBit("bp_stall_ready", bus.in_ready, 1'b0);
        checkBit("bp_stall_valid", bus.out_valid, 1'b1);
        checkRes("bp_hold_a", observe(), e1);
        @(posedge clk); #1;
        @(negedge clk);
        checkBit("bp_stall_ready2", bus.in_ready, 1'b0);
        checkRes("bp_hold_b", observe(), e1);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        checkBit("bp_pop_accept", bus.in_ready, 1'b1);
        checkRes("bp_pop1", observe(), e1);
        @(posedge clk); #1;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        checkBit("bp_pop2_valid", bus.out_valid, 1'b1);
        checkRes("bp_pop2", observe(), e2);
        @(posedge clk); #1;
        @(negedge clk);
        checkBit("bp_pop3_valid", bus.out_valid, 1'b1);
        checkRes("bp_pop3", observe(), e3);
        @(posedge clk); #1;
        @(negedge clk);
        checkBit("bp_empty", bus.out_valid, 1'b0);
        @(posedge clk); #1;

        // Reset with two pairs in flight: both must vanish.
        bus.out_ready = 1'b0;
        drive(1'b1, randOperand(), randOperand(), 1'b0);
        @(posedge clk); #1;
        drive(1'b1, randOperand(), randOperand(), 1'b1);
        @(posedge clk); #1;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkBit("rst_flight_valid", bus.out_valid, 1'b0);
        checkBit("rst_flight_ready", bus.in_ready, 1'b1);
        bus.out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        checkInt("rst_flight_discard", seen, 0);
        @(posedge clk); #1;

        // Random traffic against the reference model.
        exp_q.delete();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, randOperand(), randOperand(), 1'($urandom));
            bus.out_ready = $urandom_range(0, 3) != 0;
            tick();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        checkInt("rand_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fpaddsub_prealign_pipe.md
Name: fpaddsub_prealign_pipe

Overview:
- Parametrised, pipelined pre-alignment stage for the FP adder/subtractor.
- Unpacks two IEEE-style operands, classifies them (zero/denormal/inf/NaN) and applies the add/sub op to B's sign.
- Orders the operands by magnitude and produces the larger exponent and a saturated alignment shift.
- Uses a valid/ready handshake and feeds the alignment/shift stage.

Parameters:
- EXP_W, 8: exponent width.
- MAN_W, 23: stored fraction width.
- GRD_W, 1: zero bits appended below the fraction (guard).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept the pair this cycle.
- in_a  in  1+EXP_W+MAN_W  operand A {sign, exp, frac}.
- in_b  in  1+EXP_W+MAN_W  operand B.
- in_op  in  1  0 = A+B, 1 = A−B.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_sx  out  1  sign of the larger-magnitude operand X.
- out_sy  out  1  effective sign of the smaller operand Y (B's sign XOR in_op applied before the swap).
- out_ex  out  EXP_W  X's exponent (denormal/zero shown as 1).
- out_mx, out_my  out  MAN_W+1+GRD_W  {hidden bit, frac, GRD_W zeros}.
- out_shift  out  EXP_W  ex − ey, saturated to MAN_W+GRD_W+2.
- out_swap  out  1  1 when B became X.
- out_nan  out  1  result is NaN.
- out_inf  out  1  result is ±inf, sign = out_sx.

Behaviour:
- Two register stages S1 and S2, each with its own valid bit. Latency is 2 cycles with no stall; throughput is 1 pair per cycle.
- S1, on transfer in (in_valid & in_ready):
  - Unpack A and B. Apply in_op to B's sign.
  - Per operand, set exp_zero = ~|exp and exp_ones = &exp.
  - Biased exponent = 1 if exp_zero, else the stored exponent.
  - Mantissa = {~exp_zero, frac, GRD_W'b0}.
  - Flags: isinf = exp_ones & frac==0; isnan = exp_ones & frac!=0.
- S2, on transfer from S1:
  - Compare {exp, mantissa} of A and B as unsigned. If B > A, swap (out_swap = 1); on equality, no swap.
  - out_shift = min(ex − ey, MAN_W+GRD_W+2).
  - out_nan = either isnan, or both inf with differing effective signs.
  - out_inf = any inf & ~out_nan.
- Handshake:
  - S2 advances when !s2_valid | out_ready. S1 advances when !s1_valid | S2 advances. in_ready = S1 advances.
  - in_ready is combinational from out_ready and the valid bits.
  - While out_valid & !out_ready, all outputs are held stable.
  - in_data is ignored when !in_valid.
  - A simultaneous push and pop on a full pipe is permitted and keeps full throughput.
- Reset (rst_n low at a clk edge):
  - s1_valid, s2_valid and out_valid clear to 0, and all data/flag outputs clear to 0.
  - Reset mid-operation discards in-flight pairs.
  - in_ready is 1 in the cycle after reset is released.
- Arithmetic: exponents are unsigned. The difference is computed in EXP_W+1 bits; after ordering it is never negative.

Optional Feature:
- Macro FPADDSUB_DENORM_EN.
- Defined: denormals keep their fraction (hidden bit 0, exponent 1), i.e. gradual-underflow input.
- Undefined: flush-to-zero. Any operand with exp_zero gets mantissa forced to 0 and keeps its sign; exponent is still reported as 1.

Test Plan (EXP_W=8, MAN_W=23, GRD_W=1):
- A=0x3F800000, B=0x40000000, op=0, out_ready=1 → two cycles later: out_swap=1, out_ex=0x80, out_shift=1, out_mx=out_my=0x1000000, out_sx=out_sy=0, nan=inf=0.
- A=0x00000001, B=0x00000000, op=0:
  - With DENORM_EN: out_ex=1, out_mx=0x0000002, out_shift=0, swap=0.
  - Without: out_mx=0.
- A=0x7F800000, B=0x7F800000, op=1 → out_nan=1, out_inf=0. Same inputs with op=0 → out_inf=1, out_sx=0.
- A=0x7F000000, B=0x3F800000 → out_ex=0xFE, out_shift=26 (saturated from 127), swap=0.
- Backpressure: out_ready=0, push 3 pairs back-to-back:
  - Pairs 1–2 are accepted; in_ready drops in the 3rd cycle; out_valid holds pair 1 unchanged.
  - Raise out_ready: pairs pop in order, one per cycle, and pair 3 is accepted the same cycle as the first pop.
- Reset mid-flight: two pairs in the pipe, assert rst_n=0 for 1 cycle → next cycle out_valid=0, in_ready=1; neither pair ever appears.
